// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: branch predictor counter encodings and the
// prediction fields carried through the IF_ID and ID_EX registers.
package cpu_pkg;

  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT  = 2'b10;
  localparam logic [1:0] BP_ST  = 2'b11;

  localparam int BP_ENTRIES = 16;

  localparam int PRED_TAKEN_W = 1;
  localparam int PRED_PC_W    = 32;

  typedef struct packed {
    logic [PRED_TAKEN_W-1:0] taken;
    logic [PRED_PC_W-1:0]    pc;
  } bp_pred_t;

endpackage

// File: rtl/bp_sat_counter2.sv
// Two-bit saturating direction counter, next-state only.
// Holds at ST when taken and at SNT when not taken.
module bp_sat_counter2
  import cpu_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      (taken && (cnt != BP_ST)):   cnt_nxt = cnt + 2'd1;
      (!taken && (cnt != BP_SNT)): cnt_nxt = cnt - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: async lookup in IF,
// training and mispredict detection from EX.
module branch_predictor_btb
  import cpu_pkg::*;
#(
  parameter int         ENTRIES  = BP_ENTRIES,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0] CNT_INIT = BP_WT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_IF,
  output logic        pred_taken_IF,
  output logic [31:0] pred_pc_IF,
  input  logic        upd_valid_EX,
  input  logic [31:0] upd_pc_EX,
  input  logic        upd_is_jal_EX,
  input  logic        upd_taken_EX,
  input  logic [31:0] upd_target_EX,
  input  logic        pred_taken_EX,
  input  logic [31:0] pred_pc_EX,
  output logic        mispredict_EX,
  output logic [31:0] redirect_pc_EX,
  output logic [31:0] stat_br_cnt,
  output logic [31:0] stat_miss_cnt
);

  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_jal;
  logic [1:0]         r_cnt [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [31:0]        r_br_cnt;
  logic [31:0]        r_miss_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic             w_train;
  logic             w_alloc;
  logic [1:0]       w_cnt_nxt;

  assign w_if_idx = pc_IF[IDX_W+1:2];
  assign w_if_tag = pc_IF[31:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] &&
                    (r_tag[w_if_idx] == w_if_tag);

  assign pred_taken_IF = w_if_hit &&
                         (r_cnt[w_if_idx][1] || r_jal[w_if_idx]);
  assign pred_pc_IF    = pred_taken_IF ? r_tgt[w_if_idx]
                                       : pc_IF + 32'd4;

  assign w_up_idx = upd_pc_EX[IDX_W+1:2];
  assign w_up_tag = upd_pc_EX[31:IDX_W+2];
  assign w_up_hit = r_valid[w_up_idx] &&
                    (r_tag[w_up_idx] == w_up_tag);

  assign w_train = upd_valid_EX && w_up_hit;
  assign w_alloc = upd_valid_EX && !w_up_hit && upd_taken_EX;

  bp_sat_counter2 u_cnt (
    .cnt     (r_cnt[w_up_idx]),
    .taken   (upd_taken_EX),
    .cnt_nxt (w_cnt_nxt)
  );

  always_comb begin
    mispredict_EX  = 1'b0;
    redirect_pc_EX = 32'd0;
    if (upd_valid_EX) begin
      mispredict_EX = (pred_taken_EX != upd_taken_EX) ||
                      (upd_taken_EX &&
                       (pred_pc_EX != upd_target_EX));
      redirect_pc_EX = upd_taken_EX ? upd_target_EX
                                    : upd_pc_EX + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_br_cnt   <= 32'd0;
      r_miss_cnt <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= BP_SNT;
      end
    end else begin
      if (upd_valid_EX) r_br_cnt <= r_br_cnt + 32'd1;
      if (mispredict_EX) r_miss_cnt <= r_miss_cnt + 32'd1;
      if (w_train) begin
        r_cnt[w_up_idx] <= w_cnt_nxt;
      end else if (w_alloc) begin
        r_valid[w_up_idx] <= 1'b1;
        r_cnt[w_up_idx]   <= upd_is_jal_EX ? BP_ST : CNT_INIT;
      end
    end
  end

  // Tag/target/kind need no reset: they are qualified by r_valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_alloc || (w_train && upd_taken_EX)) begin
        r_tgt[w_up_idx] <= upd_target_EX;
      end
      if (w_alloc) begin
        r_tag[w_up_idx] <= w_up_tag;
        r_jal[w_up_idx] <= upd_is_jal_EX;
      end
    end
  end

  assign stat_br_cnt   = r_br_cnt;
  assign stat_miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: reset, allocation, counter
// training, aliasing, same-cycle read/write, JAL and mid-update reset.
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst;
  logic [31:0] pc_IF;
  logic        pred_taken_IF;
  logic [31:0] pred_pc_IF;
  logic        upd_valid_EX;
  logic [31:0] upd_pc_EX;
  logic        upd_is_jal_EX;
  logic        upd_taken_EX;
  logic [31:0] upd_target_EX;
  logic        pred_taken_EX;
  logic [31:0] pred_pc_EX;
  logic        mispredict_EX;
  logic [31:0] redirect_pc_EX;
  logic [31:0] stat_br_cnt;
  logic [31:0] stat_miss_cnt;

  int n_pass;
  int n_total;

  branch_predictor_btb dut (
    .clk            (clk),
    .rst            (rst),
    .pc_IF          (pc_IF),
    .pred_taken_IF  (pred_taken_IF),
    .pred_pc_IF     (pred_pc_IF),
    .upd_valid_EX   (upd_valid_EX),
    .upd_pc_EX      (upd_pc_EX),
    .upd_is_jal_EX  (upd_is_jal_EX),
    .upd_taken_EX   (upd_taken_EX),
    .upd_target_EX  (upd_target_EX),
    .pred_taken_EX  (pred_taken_EX),
    .pred_pc_EX     (pred_pc_EX),
    .mispredict_EX  (mispredict_EX),
    .redirect_pc_EX (redirect_pc_EX),
    .stat_br_cnt    (stat_br_cnt),
    .stat_miss_cnt  (stat_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_upd(
    input logic        v,
    input logic [31:0] pc,
    input logic        jal,
    input logic        tk,
    input logic [31:0] tgt,
    input logic        ptk,
    input logic [31:0] ppc
  );
    upd_valid_EX  = v;
    upd_pc_EX     = pc;
    upd_is_jal_EX = jal;
    upd_taken_EX  = tk;
    upd_target_EX = tgt;
    pred_taken_EX = ptk;
    pred_pc_EX    = ppc;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    pc_IF = 32'h100;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b0)
      $display("FAIL rst_pred_taken got %0h exp 0", pred_taken_IF);
    else n_pass++;
    n_total++;
    if (pred_pc_IF !== 32'h104)
      $display("FAIL rst_pred_pc got %h exp 00000104", pred_pc_IF);
    else n_pass++;
    n_total++;
    if (stat_br_cnt !== 32'd0)
      $display("FAIL rst_br_cnt got %0d exp 0", stat_br_cnt);
    else n_pass++;
    n_total++;
    if (stat_miss_cnt !== 32'd0)
      $display("FAIL rst_miss_cnt got %0d exp 0", stat_miss_cnt);
    else n_pass++;
    n_total++;
    if (mispredict_EX !== 1'b0 || redirect_pc_EX !== 32'd0)
      $display("FAIL idle_ex got %0h/%h exp 0/0",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    pc_IF = 32'hFFFF_FFFC;
    #1;
    n_total++;
    if (pred_pc_IF !== 32'd0)
      $display("FAIL pc_wrap got %h exp 00000000", pred_pc_IF);
    else n_pass++;
  endtask

  task automatic test_alloc();
    @(negedge clk);
    pc_IF = 32'h100;
    set_upd(1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b1 || redirect_pc_EX !== 32'h80)
      $display("FAIL alloc_mis got %0h/%h exp 1/00000080",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    n_total++;
    if (pred_taken_IF !== 1'b0)
      $display("FAIL alloc_pre got %0h exp 0", pred_taken_IF);
    else n_pass++;
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b1 || pred_pc_IF !== 32'h80)
      $display("FAIL alloc_pred got %0h/%h exp 1/00000080",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    n_total++;
    if (stat_br_cnt !== 32'd1 || stat_miss_cnt !== 32'd1)
      $display("FAIL alloc_stats got %0d/%0d exp 1/1",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
  endtask

  // Counter starts at WT: walk it down to SNT, hold, then up to ST, hold.
  task automatic test_counter();
    logic tk   [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    logic ptk  [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    logic emis [8] = '{1, 0, 0, 1, 1, 0, 0, 1};
    logic epred[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic [31:0] eredir;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pc_IF = 32'h100;
      set_upd(1, 32'h100, 0, tk[i], 32'h80, ptk[i],
              ptk[i] ? 32'h80 : 32'h104);
      eredir = tk[i] ? 32'h80 : 32'h104;
      #1;
      n_total++;
      if (mispredict_EX !== emis[i] || redirect_pc_EX !== eredir)
        $display("FAIL cnt_mis[%0d] got %0h/%h exp %0h/%h", i,
                 mispredict_EX, redirect_pc_EX, emis[i], eredir);
      else n_pass++;
      @(negedge clk);
      set_upd(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_total++;
      if (pred_taken_IF !== epred[i])
        $display("FAIL cnt_pred[%0d] got %0h exp %0h", i,
                 pred_taken_IF, epred[i]);
      else n_pass++;
    end
    n_total++;
    if (stat_br_cnt !== 32'd9 || stat_miss_cnt !== 32'd5)
      $display("FAIL cnt_stats got %0d/%0d exp 9/5",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
  endtask

  task automatic test_alias();
    @(negedge clk);
    set_upd(1, 32'h140, 0, 1, 32'hA0, 0, 32'h144);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b1 || redirect_pc_EX !== 32'hA0)
      $display("FAIL alias_mis got %0h/%h exp 1/000000a0",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0, 0, 0);
    pc_IF = 32'h100;
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b0 || pred_pc_IF !== 32'h104)
      $display("FAIL alias_old got %0h/%h exp 0/00000104",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    pc_IF = 32'h140;
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b1 || pred_pc_IF !== 32'hA0)
      $display("FAIL alias_new got %0h/%h exp 1/000000a0",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    n_total++;
    if (stat_br_cnt !== 32'd10 || stat_miss_cnt !== 32'd6)
      $display("FAIL alias_stats got %0d/%0d exp 10/6",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pc_IF = 32'h140;
    set_upd(1, 32'h140, 0, 1, 32'hC0, 1, 32'hA0);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b1 || redirect_pc_EX !== 32'hC0)
      $display("FAIL b2b_mis got %0h/%h exp 1/000000c0",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    n_total++;
    if (pred_pc_IF !== 32'hA0)
      $display("FAIL b2b_old got %h exp 000000a0", pred_pc_IF);
    else n_pass++;
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b1 || pred_pc_IF !== 32'hC0)
      $display("FAIL b2b_new got %0h/%h exp 1/000000c0",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    n_total++;
    if (stat_br_cnt !== 32'd11 || stat_miss_cnt !== 32'd7)
      $display("FAIL b2b_stats got %0d/%0d exp 11/7",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
  endtask

  task automatic test_jal();
    @(negedge clk);
    set_upd(1, 32'h200, 1, 1, 32'h300, 0, 32'h204);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b1 || redirect_pc_EX !== 32'h300)
      $display("FAIL jal_alloc got %0h/%h exp 1/00000300",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0, 0, 0);
    pc_IF = 32'h202;
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b1 || pred_pc_IF !== 32'h300)
      $display("FAIL jal_pred got %0h/%h exp 1/00000300",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    @(negedge clk);
    set_upd(1, 32'h200, 1, 1, 32'h300, 1, 32'h2F0);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b1 || redirect_pc_EX !== 32'h300)
      $display("FAIL jal_badtgt got %0h/%h exp 1/00000300",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    @(negedge clk);
    set_upd(1, 32'h200, 1, 1, 32'h300, 1, 32'h300);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b0)
      $display("FAIL jal_good got %0h exp 0", mispredict_EX);
    else n_pass++;
    n_total++;
    if (stat_br_cnt !== 32'd13 || stat_miss_cnt !== 32'd9)
      $display("FAIL jal_stats_mid got %0d/%0d exp 13/9",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (stat_br_cnt !== 32'd14 || stat_miss_cnt !== 32'd9)
      $display("FAIL jal_stats got %0d/%0d exp 14/9",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    set_upd(1, 32'h100, 0, 1, 32'h80, 0, 32'h104);
    #1;
    n_total++;
    if (mispredict_EX !== 1'b1 || redirect_pc_EX !== 32'h80)
      $display("FAIL rstmid_mis got %0h/%h exp 1/00000080",
               mispredict_EX, redirect_pc_EX);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    pc_IF = 32'h200;
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b0 || pred_pc_IF !== 32'h204)
      $display("FAIL rstmid_jal got %0h/%h exp 0/00000204",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    pc_IF = 32'h100;
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b0 || pred_pc_IF !== 32'h104)
      $display("FAIL rstmid_upd got %0h/%h exp 0/00000104",
               pred_taken_IF, pred_pc_IF);
    else n_pass++;
    n_total++;
    if (stat_br_cnt !== 32'd0 || stat_miss_cnt !== 32'd0)
      $display("FAIL rstmid_stats got %0d/%0d exp 0/0",
               stat_br_cnt, stat_miss_cnt);
    else n_pass++;
    // A fresh not-taken update must not allocate after reset.
    @(negedge clk);
    set_upd(1, 32'h100, 0, 0, 32'h80, 0, 32'h104);
    @(negedge clk);
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    n_total++;
    if (pred_taken_IF !== 1'b0 || stat_br_cnt !== 32'd1)
      $display("FAIL nt_noalloc got %0h/%0d exp 0/1",
               pred_taken_IF, stat_br_cnt);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_back_to_back();
    test_jal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
